// File: rtl/snn_interfaces_pkg.sv
// Shared types for the spiking-network datapath: coordinates, pixel events,
// default geometry and the event transmitter FSM encoding.
package snn_interfaces_pkg;

  localparam int unsigned DEFAULT_COORD_BITS       = 8;
  localparam int unsigned DEFAULT_IN_CHANNELS      = 4;
  localparam int unsigned DEFAULT_IMG_WIDTH        = 32;
  localparam int unsigned DEFAULT_IMG_HEIGHT       = 32;
  localparam int unsigned DEFAULT_EVENT_FIFO_DEPTH = 16;

  typedef struct packed {
    logic [DEFAULT_COORD_BITS-1:0] x;
    logic [DEFAULT_COORD_BITS-1:0] y;
  } vec2_t;

  typedef struct packed {
    vec2_t                          coord;
    logic [DEFAULT_IN_CHANNELS-1:0] spikes;
  } output_vector_t;

  // Output FSM of the event transmitter, exported for debug observation.
  typedef enum logic [1:0] {
    TX_IDLE    = 2'd0,
    TX_PRESENT = 2'd1,
    TX_GAP     = 2'd2
  } tx_state_e;

endpackage

// File: rtl/event_fifo.sv
// Synchronous FIFO of pixel events with head read and occupancy count.
// Optional feature macro: EVENT_COALESCE_EN adds a tail-merge port that ORs
// spikes into the most recently written entry without changing occupancy.
import snn_interfaces_pkg::*;

module event_fifo #(
  parameter int unsigned DEPTH = DEFAULT_EVENT_FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  output_vector_t             push_data_i,
  input  logic                       pop_i,
  output output_vector_t             head_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o
`ifdef EVENT_COALESCE_EN
  ,
  input  logic                       merge_i,
  input  logic [DEFAULT_IN_CHANNELS-1:0] merge_spikes_i,
  output output_vector_t             tail_o
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  output_vector_t  mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            push_ok, pop_ok;

  // Pointers are AW bits wide, so wrap modulo DEPTH happens for free.
  assign full_o  = (count_q == CW'(DEPTH));
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && (count_q != '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

`ifdef EVENT_COALESCE_EN
  logic [AW-1:0] tail_idx;
  assign tail_idx = wr_ptr_q - 1'b1;
  assign tail_o   = mem_q[tail_idx];
`endif

  // Storage array: written on push, tail spikes OR-ed on merge; no reset needed.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
`ifdef EVENT_COALESCE_EN
    if (merge_i) begin
      mem_q[tail_idx].spikes <= mem_q[tail_idx].spikes | merge_spikes_i;
    end
`endif
  end

  // Pointer and occupancy bookkeeping; push+pop together leaves count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/event_transmitter.sv
// Event transmitter: filters incoming pixel events, buffers them in a FIFO and
// presents them one at a time on a valid/ack handshake with a one-cycle gap
// between events.
// Optional feature macro: EVENT_COALESCE_EN merges a same-pixel event into the
// FIFO tail instead of pushing it.
//
// Handshakes: upstream transfers when in_valid && in_ready at a rising edge
// (in_ready depends only on the registered count). Downstream, event_out is
// held stable while event_valid is high; a one-cycle event_ack sampled while
// presenting retires the event, and ack at any other time is ignored.
import snn_interfaces_pkg::*;

module event_transmitter #(
  parameter int unsigned COORD_BITS  = DEFAULT_COORD_BITS,
  parameter int unsigned IN_CHANNELS = DEFAULT_IN_CHANNELS,
  parameter int unsigned IMG_WIDTH   = DEFAULT_IMG_WIDTH,
  parameter int unsigned IMG_HEIGHT  = DEFAULT_IMG_HEIGHT,
  parameter int unsigned FIFO_DEPTH  = DEFAULT_EVENT_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  output_vector_t                in_event,
  input  logic                          in_valid,
  output logic                          in_ready,
  output output_vector_t                event_out,
  output logic                          event_valid,
  input  logic                          event_ack,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [7:0]                    oob_count,
  output tx_state_e                     dbg_state_o
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [COORD_BITS-1:0]  ev_x, ev_y;
  logic [IN_CHANNELS-1:0] ev_spikes;
  logic                   accept, in_range, ev_ok, push, pop, full;
  logic [CW-1:0]          count;
  output_vector_t         head;

  tx_state_e      state_q;
  output_vector_t event_out_q;
  logic           event_valid_q;
  logic [7:0]     oob_q;

  assign ev_x      = in_event.coord.x;
  assign ev_y      = in_event.coord.y;
  assign ev_spikes = in_event.spikes;

  assign in_ready = !full;
  assign accept   = in_valid && in_ready;
  assign in_range = (32'(ev_x) < IMG_WIDTH) && (32'(ev_y) < IMG_HEIGHT);
  assign ev_ok    = (ev_spikes != '0) && in_range;
  assign pop      = (state_q == TX_PRESENT) && event_ack;

`ifdef EVENT_COALESCE_EN
  // With one entry the tail is the head, which is either latched in PRESENT
  // or being latched this very edge, so merging needs at least two entries.
  output_vector_t tail;
  logic           merge;
  assign merge = accept && ev_ok && (count >= CW'(2)) &&
                 (tail.coord == in_event.coord);
  assign push  = accept && ev_ok && !merge;
`else
  assign push  = accept && ev_ok;
`endif

  event_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_data_i (in_event),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (count),
    .full_o      (full)
`ifdef EVENT_COALESCE_EN
    ,
    .merge_i        (merge),
    .merge_spikes_i (in_event.spikes),
    .tail_o         (tail)
`endif
  );

  // Output FSM: latch head, present until ack, then force one idle gap cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= TX_IDLE;
      event_out_q   <= '0;
      event_valid_q <= 1'b0;
    end else begin
      case (state_q)
        TX_IDLE: begin
          if (count != '0) begin
            event_out_q   <= head;
            event_valid_q <= 1'b1;
            state_q       <= TX_PRESENT;
          end
        end
        TX_PRESENT: begin
          if (event_ack) begin
            event_valid_q <= 1'b0;
            state_q       <= TX_GAP;
          end
        end
        TX_GAP: begin
          if (count != '0) begin
            event_out_q   <= head;
            event_valid_q <= 1'b1;
            state_q       <= TX_PRESENT;
          end else begin
            state_q       <= TX_IDLE;
          end
        end
        default: begin
          event_valid_q <= 1'b0;
          state_q       <= TX_IDLE;
        end
      endcase
    end
  end

  // Saturating count of accepted events discarded for out-of-range coordinates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oob_q <= '0;
    end else if (accept && !in_range && (oob_q != 8'hFF)) begin
      oob_q <= oob_q + 8'd1;
    end
  end

  assign event_out   = event_out_q;
  assign event_valid = event_valid_q;
  assign fifo_count  = count;
  assign oob_count   = oob_q;
  assign dbg_state_o = state_q;

endmodule
